// File: rtl/lpm_requester.sv
// rtl/lpm_requester.sv - host command/result bridge to a longest-prefix-match engine
// One command slot, an in-order key FIFO for outstanding lookups, and one result slot.
module lpm_requester #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     cmd__ENA,
  input  logic                     cmd_op,
  input  logic [WIDTH-1:0]         cmd_addr,
  input  logic [WIDTH-1:0]         cmd_data,
  output logic                     cmd__RDY,
  output logic                     enter__ENA,
  output logic [WIDTH-1:0]         enter_data,
  input  logic                     enter__RDY,
  output logic                     write__ENA,
  output logic [WIDTH-1:0]         write_addr,
  output logic [WIDTH-1:0]         write_data,
  input  logic                     write__RDY,
  input  logic                     out__ENA,
  input  logic [WIDTH-1:0]         out_data,
  output logic                     out__RDY,
  output logic                     result__ENA,
  output logic [WIDTH-1:0]         result_key,
  output logic [WIDTH-1:0]         result_data,
  input  logic                     result__RDY,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [AW-1:0] LAST_P  = AW'(DEPTH - 1);

  logic             valid_q, valid_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] keys_q [DEPTH];
  logic [WIDTH-1:0] keys_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rkey_q, rkey_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic enter_fire, write_fire, out_ok, out_fire, res_fire;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // Writes wait for every outstanding lookup to drain so reads never see a later write.
  assign enter_fire = valid_q & ~op_q & enter__RDY & (pend_q != DEPTH_P);
  assign write_fire = valid_q &  op_q & write__RDY & (pend_q == '0);
  assign out_ok     = ~rvalid_q & (pend_q != '0);
  assign out_fire   = out__ENA & out_ok;
  assign res_fire   = rvalid_q & result__RDY;

  assign cmd__RDY    = ~valid_q;
  assign enter__ENA  = enter_fire;
  assign enter_data  = data_q;
  assign write__ENA  = write_fire;
  assign write_addr  = addr_q;
  assign write_data  = data_q;
  assign out__RDY    = out_ok;
  assign result__ENA = res_fire;
  assign result_key  = rkey_q;
  assign result_data = rdata_q;
  assign pending     = pend_q;
  assign err         = err_q;

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    keys_d   = keys_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    pend_d   = pend_q;
    rvalid_d = rvalid_q;
    rkey_d   = rkey_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    if (cmd__ENA && !valid_q) begin
      valid_d = 1'b1;
      op_d    = cmd_op;
      addr_d  = cmd_addr;
      data_d  = cmd_data;
    end else if (enter_fire || write_fire) begin
      valid_d = 1'b0;
    end

    if (enter_fire) begin
      keys_d[wptr_q] = data_q;
      wptr_d         = ptr_inc(wptr_q);
    end

    if (out_fire) begin
      rkey_d   = keys_q[rptr_q];
      rdata_d  = out_data;
      rvalid_d = 1'b1;
      rptr_d   = ptr_inc(rptr_q);
    end else if (res_fire) begin
      rvalid_d = 1'b0;
    end

    case ({enter_fire, out_fire})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase

    if (out__ENA && !out_ok) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      valid_q  <= 1'b0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) keys_q[i] <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      pend_q   <= '0;
      rvalid_q <= 1'b0;
      rkey_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      keys_q   <= keys_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      pend_q   <= pend_d;
      rvalid_q <= rvalid_d;
      rkey_q   <= rkey_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_lpm_requester.sv
// tb/tb_lpm_requester.sv - directed self-checking bench for lpm_requester
module tb_lpm_requester;

  logic        CLK;
  logic        nRST;
  logic        cmd__ENA;
  logic        cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd__RDY;
  logic        enter__ENA;
  logic [31:0] enter_data;
  logic        enter__RDY;
  logic        write__ENA;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        write__RDY;
  logic        out__ENA;
  logic [31:0] out_data;
  logic        out__RDY;
  logic        result__ENA;
  logic [31:0] result_key;
  logic [31:0] result_data;
  logic        result__RDY;
  logic [2:0]  pending;
  logic        err;

  int tests = 0;
  int fails = 0;
  int enter_cnt = 0;

  lpm_requester #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .cmd__ENA(cmd__ENA), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd__RDY(cmd__RDY),
    .enter__ENA(enter__ENA), .enter_data(enter_data), .enter__RDY(enter__RDY),
    .write__ENA(write__ENA), .write_addr(write_addr), .write_data(write_data), .write__RDY(write__RDY),
    .out__ENA(out__ENA), .out_data(out_data), .out__RDY(out__RDY),
    .result__ENA(result__ENA), .result_key(result_key), .result_data(result_data), .result__RDY(result__RDY),
    .pending(pending), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (enter__ENA) enter_cnt <= enter_cnt + 1;

  // Loads one command; returns on the negedge after the load with cmd__ENA low.
  task automatic send_cmd(input logic op, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    @(negedge CLK);
    while (!cmd__RDY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (!cmd__RDY) begin
      $display("FAIL send_cmd_timeout: cmd__RDY=%0b required 1", cmd__RDY);
      fails++;
    end
    cmd__ENA = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(negedge CLK);
    cmd__ENA = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b1;
    @(negedge CLK); #1;
    tests++;
    if ({cmd__RDY, out__RDY, enter__ENA, write__ENA, result__ENA, err} !== 6'b100000 || pending !== 3'd0) begin
      $display("FAIL reset_state: rdy/ena/err=%b pending=%0d required 100000 pending=0",
               {cmd__RDY, out__RDY, enter__ENA, write__ENA, result__ENA, err}, pending);
      fails++;
    end
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    tests++;
    if (cmd__RDY !== 1'b1 || out__RDY !== 1'b0) begin
      $display("FAIL post_reset_rdy: cmd__RDY=%b out__RDY=%b required 1 0", cmd__RDY, out__RDY);
      fails++;
    end
  endtask

  task automatic test_write;
    write__RDY = 1'b1;
    send_cmd(1'b1, 32'h10, 32'hAB);
    tests++;
    if (write__ENA !== 1'b1 || write_addr !== 32'h10 || write_data !== 32'hAB || cmd__RDY !== 1'b0) begin
      $display("FAIL write_issue: ena=%b addr=%h data=%h rdy=%b required 1 10 ab 0",
               write__ENA, write_addr, write_data, cmd__RDY);
      fails++;
    end
    @(negedge CLK); #1;
    tests++;
    if (write__ENA !== 1'b0 || cmd__RDY !== 1'b1) begin
      $display("FAIL write_done: ena=%b rdy=%b required 0 1", write__ENA, cmd__RDY);
      fails++;
    end
  endtask

  task automatic test_lookup;
    enter__RDY = 1'b1; result__RDY = 1'b1;
    send_cmd(1'b0, 32'h0, 32'h0A000001);
    tests++;
    if (enter__ENA !== 1'b1 || enter_data !== 32'h0A000001 || pending !== 3'd0) begin
      $display("FAIL lookup_enter: ena=%b data=%h pending=%0d required 1 0a000001 0",
               enter__ENA, enter_data, pending);
      fails++;
    end
    @(negedge CLK); #1;
    tests++;
    if (pending !== 3'd1 || out__RDY !== 1'b1 || enter__ENA !== 1'b0) begin
      $display("FAIL lookup_pending1: pending=%0d out__RDY=%b enter=%b required 1 1 0",
               pending, out__RDY, enter__ENA);
      fails++;
    end
    @(negedge CLK);
    out__ENA = 1'b1; out_data = 32'h5;
    @(negedge CLK);
    out__ENA = 1'b0; #1;
    tests++;
    if (result__ENA !== 1'b1 || result_key !== 32'h0A000001 || result_data !== 32'h5 || pending !== 3'd0) begin
      $display("FAIL lookup_result: ena=%b key=%h data=%h pending=%0d required 1 0a000001 5 0",
               result__ENA, result_key, result_data, pending);
      fails++;
    end
    @(negedge CLK); #1;
    tests++;
    if (result__ENA !== 1'b0) begin
      $display("FAIL lookup_result_clear: ena=%b required 0", result__ENA);
      fails++;
    end
  endtask

  task automatic test_full_ordering;
    int base;
    logic [31:0] exp_key [5];
    logic [31:0] exp_dat [5];
    exp_key = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    exp_dat = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    enter__RDY = 1'b1; result__RDY = 1'b1;
    base = enter_cnt;
    for (int k = 1; k <= 5; k++) send_cmd(1'b0, 32'h0, 32'(k));
    @(negedge CLK); #1;
    tests++;
    if (enter_cnt - base !== 4 || pending !== 3'd4 || enter__ENA !== 1'b0 || cmd__RDY !== 1'b0) begin
      $display("FAIL full_stall: enters=%0d pending=%0d enter=%b rdy=%b required 4 4 0 0",
               enter_cnt - base, pending, enter__ENA, cmd__RDY);
      fails++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      out__ENA = 1'b1; out_data = exp_dat[i];
      #1;
      tests++;
      if (out__RDY !== 1'b1) begin
        $display("FAIL full_out_rdy%0d: out__RDY=%b required 1", i, out__RDY);
        fails++;
      end
      @(negedge CLK);
      out__ENA = 1'b0; #1;
      tests++;
      if (result__ENA !== 1'b1 || result_key !== exp_key[i] || result_data !== exp_dat[i]) begin
        $display("FAIL full_result%0d: ena=%b key=%h data=%h required 1 %h %h",
                 i, result__ENA, result_key, result_data, exp_key[i], exp_dat[i]);
        fails++;
      end
      if (i == 0) begin
        tests++;
        if (enter__ENA !== 1'b1 || enter_data !== 32'd5) begin
          $display("FAIL full_key5_issue: enter=%b data=%h required 1 5", enter__ENA, enter_data);
          fails++;
        end
      end
    end
    @(negedge CLK); #1;
    tests++;
    if (pending !== 3'd0 || enter_cnt - base !== 5) begin
      $display("FAIL full_drain: pending=%0d enters=%0d required 0 5", pending, enter_cnt - base);
      fails++;
    end
  endtask

  task automatic test_fence;
    enter__RDY = 1'b1; write__RDY = 1'b1; result__RDY = 1'b1;
    send_cmd(1'b0, 32'h0, 32'h7);
    send_cmd(1'b1, 32'h3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (write__ENA !== 1'b0 || cmd__RDY !== 1'b0 || pending !== 3'd1) begin
        $display("FAIL fence_stall%0d: write=%b rdy=%b pending=%0d required 0 0 1",
                 i, write__ENA, cmd__RDY, pending);
        fails++;
      end
      @(negedge CLK); #1;
    end
    out__ENA = 1'b1; out_data = 32'h77;
    #1;
    tests++;
    if (write__ENA !== 1'b0) begin
      $display("FAIL fence_same_cycle: write=%b required 0", write__ENA);
      fails++;
    end
    @(negedge CLK);
    out__ENA = 1'b0; #1;
    tests++;
    if (write__ENA !== 1'b1 || write_addr !== 32'h3 || write_data !== 32'h33 ||
        result__ENA !== 1'b1 || result_key !== 32'h7 || result_data !== 32'h77) begin
      $display("FAIL fence_release: write=%b addr=%h data=%h res=%b key=%h rdata=%h required 1 3 33 1 7 77",
               write__ENA, write_addr, write_data, result__ENA, result_key, result_data);
      fails++;
    end
    @(negedge CLK); #1;
  endtask

  task automatic test_backpressure;
    enter__RDY = 1'b1; result__RDY = 1'b0;
    send_cmd(1'b0, 32'h0, 32'h21);
    send_cmd(1'b0, 32'h0, 32'h22);
    @(negedge CLK);
    out__ENA = 1'b1; out_data = 32'h1;
    @(negedge CLK);
    out__ENA = 1'b0; #1;
    tests++;
    if (result__ENA !== 1'b0 || out__RDY !== 1'b0 || pending !== 3'd1) begin
      $display("FAIL bp_hold: res=%b out__RDY=%b pending=%0d required 0 0 1", result__ENA, out__RDY, pending);
      fails++;
    end
    enter__RDY = 1'b0;
    send_cmd(1'b0, 32'h0, 32'h23);
    tests++;
    if (enter__ENA !== 1'b0 || out__RDY !== 1'b0) begin
      $display("FAIL bp_enter_block: enter=%b out__RDY=%b required 0 0", enter__ENA, out__RDY);
      fails++;
    end
    @(negedge CLK);
    result__RDY = 1'b1; #1;
    tests++;
    if (result__ENA !== 1'b1 || result_key !== 32'h21 || result_data !== 32'h1) begin
      $display("FAIL bp_release: res=%b key=%h data=%h required 1 21 1", result__ENA, result_key, result_data);
      fails++;
    end
    @(negedge CLK);
    enter__RDY = 1'b1; out__ENA = 1'b1; out_data = 32'h2; #1;
    tests++;
    if (enter__ENA !== 1'b1 || out__RDY !== 1'b1 || pending !== 3'd1) begin
      $display("FAIL simul_setup: enter=%b out__RDY=%b pending=%0d required 1 1 1", enter__ENA, out__RDY, pending);
      fails++;
    end
    @(negedge CLK);
    out__ENA = 1'b0; #1;
    tests++;
    if (pending !== 3'd1 || result__ENA !== 1'b1 || result_key !== 32'h22 || result_data !== 32'h2) begin
      $display("FAIL simul_pending: pending=%0d res=%b key=%h data=%h required 1 1 22 2",
               pending, result__ENA, result_key, result_data);
      fails++;
    end
    @(negedge CLK);
    out__ENA = 1'b1; out_data = 32'h3;
    @(negedge CLK);
    out__ENA = 1'b0; #1;
    tests++;
    if (pending !== 3'd0 || result_key !== 32'h23 || result_data !== 32'h3 || err !== 1'b0) begin
      $display("FAIL bp_drain: pending=%0d key=%h data=%h err=%b required 0 23 3 0",
               pending, result_key, result_data, err);
      fails++;
    end
    @(negedge CLK); #1;
  endtask

  task automatic test_error_reset;
    result__RDY = 1'b1; enter__RDY = 1'b1;
    @(negedge CLK);
    out__ENA = 1'b1; out_data = 32'h99;
    @(negedge CLK);
    out__ENA = 1'b0; #1;
    tests++;
    if (err !== 1'b1 || result__ENA !== 1'b0 || pending !== 3'd0) begin
      $display("FAIL err_set: err=%b res=%b pending=%0d required 1 0 0", err, result__ENA, pending);
      fails++;
    end
    send_cmd(1'b0, 32'h0, 32'h31);
    send_cmd(1'b0, 32'h0, 32'h32);
    @(negedge CLK); #1;
    tests++;
    if (pending !== 3'd2 || err !== 1'b1) begin
      $display("FAIL err_sticky_pending2: pending=%0d err=%b required 2 1", pending, err);
      fails++;
    end
    nRST = 1'b1; #1;
    tests++;
    if (pending !== 3'd0 || err !== 1'b0 || cmd__RDY !== 1'b1 || out__RDY !== 1'b0) begin
      $display("FAIL reset_mid: pending=%0d err=%b cmd__RDY=%b out__RDY=%b required 0 0 1 0",
               pending, err, cmd__RDY, out__RDY);
      fails++;
    end
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    out__ENA = 1'b1; out_data = 32'h44;
    @(negedge CLK);
    out__ENA = 1'b0; #1;
    tests++;
    if (err !== 1'b1 || result__ENA !== 1'b0 || pending !== 3'd0) begin
      $display("FAIL late_response: err=%b res=%b pending=%0d required 1 0 0", err, result__ENA, pending);
      fails++;
    end
  endtask

  initial begin
    nRST = 1'b1;
    cmd__ENA = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = '0;
    enter__RDY = 1'b0; write__RDY = 1'b0; out__ENA = 1'b0; out_data = '0; result__RDY = 1'b0;
    test_reset;
    test_write;
    test_lookup;
    test_full_ordering;
    test_fence;
    test_backpressure;
    test_error_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
